pcie_tx_tlp_arbiter: RTL and testbench

- Shares the single transmit TLP stream toward the data-link layer between three TLP sources: 0 = completion (Cpl/CplD), 1 = posted (MWr), 2 = non-posted (MRd).
- Each source presents whole, multi-beat TLPs.
- The arbiter grants one source at a time, round-robin, gated by per-class flow-control credit.
- It holds the grant until the end-of-packet beat and drives a one-stage registered output stream.

---
 rtl/pcie_tx_tlp_arbiter.sv | 143 ++++++++++++++
 tb/tb_pcie_tx_tlp_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tx_tlp_arbiter.sv
// pcie_tx_tlp_arbiter
//   Shares one transmit TLP stream between NUM_SRC packet sources
//   (0 = completion, 1 = posted, 2 = non-posted). A source wins only when it
//   presents a start-of-packet beat and its class has flow-control credit.
//   Arbitration is round-robin, and the grant is held until the end-of-packet
//   beat. Output beats leave through a single registered stage.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no grant held; scan for an eligible source, accept nothing
//   LOCK  | grant held; forward the granted source's beats until eop
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   src_valid      per-source beat valid
//   src_ready      per-source beat accept
//   src_data       beats, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_sop/eop    first / last beat of a TLP
//   src_credit_ok  class has credit for its head TLP (sampled at arbitration)
//   tx_valid/ready output stream handshake
//   tx_data        output beat
//   tx_sop/eop     output first / last beat
//   tx_src_id      source index of the output beat
//   busy           a packet grant is held
//   sop_err        sticky: sop seen on a non-first beat of a grant
module pcie_tx_tlp_arbiter #(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_SRC    = 3,
  parameter int SRC_ID_W   = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_sop,
  input  logic [NUM_SRC-1:0]            src_eop,
  input  logic [NUM_SRC-1:0]            src_credit_ok,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_sop,
  output logic                          tx_eop,
  output logic [SRC_ID_W-1:0]           tx_src_id,
  output logic                          busy,
  output logic                          sop_err
);

  typedef enum logic {IDLE, LOCK} state_t;

  localparam logic [SRC_ID_W-1:0] LAST_ID = SRC_ID_W'(NUM_SRC - 1);

  state_t                state;
  state_t                state_nxt;
  logic [SRC_ID_W-1:0]   grant;
  logic [SRC_ID_W-1:0]   rr_ptr;
  logic [SRC_ID_W-1:0]   pick;
  logic                  pick_vld;
  logic                  first_beat;
  logic                  out_free;
  logic                  accept;
  logic [NUM_SRC-1:0]    elig;
  logic [DATA_WIDTH-1:0] lane [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    assign lane[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign elig = src_valid & src_sop & src_credit_ok;

  // Round-robin scan starting at rr_ptr. The index wraps by explicit compare
  // because NUM_SRC need not be a power of two.
  always_comb begin : arb_scan
    logic [SRC_ID_W-1:0] idx;
    pick     = rr_ptr;
    pick_vld = 1'b0;
    idx      = rr_ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!pick_vld && elig[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
      idx = (idx == LAST_ID) ? '0 : idx + SRC_ID_W'(1);
    end
  end

  // The output register can take a beat when empty or draining this cycle.
  assign out_free = ~tx_valid | tx_ready;
  assign accept   = (state == LOCK) & src_valid[grant] & out_free;
  assign busy     = (state == LOCK);

  always_comb begin
    src_ready = '0;
    if (state == LOCK) src_ready[grant] = src_valid[grant] & out_free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = LOCK;
      LOCK:    if (accept && src_eop[grant]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= '0;
      rr_ptr     <= '0;
      first_beat <= 1'b0;
      sop_err    <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      tx_sop     <= 1'b0;
      tx_eop     <= 1'b0;
      tx_src_id  <= '0;
    end else begin
      if (state == IDLE && pick_vld) begin
        grant      <= pick;
        first_beat <= 1'b1;
      end
      if (accept) begin
        first_beat <= 1'b0;
        // A repeated sop is flagged but the beat is still forwarded.
        if (src_sop[grant] && !first_beat) sop_err <= 1'b1;
        if (src_eop[grant]) rr_ptr <= (grant == LAST_ID) ? '0 : grant + SRC_ID_W'(1);
        tx_valid  <= 1'b1;
        tx_data   <= lane[grant];
        tx_sop    <= src_sop[grant];
        tx_eop    <= src_eop[grant];
        tx_src_id <= grant;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcie_tx_tlp_arbiter.sv
// Bench for pcie_tx_tlp_arbiter: directed per-cycle vector table, hand-written
// credit / sop-error / reset sequences, round-robin order check and a random
// run against a packet-level reference model with a beat scoreboard.
module tb_pcie_tx_tlp_arbiter;
  localparam int DW = 256;
  localparam int NS = 3;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NS-1:0]     src_valid, src_ready, src_sop, src_eop, src_credit_ok;
  logic [NS*DW-1:0]  src_data;
  logic              tx_valid, tx_ready, tx_sop, tx_eop, busy, sop_err;
  logic [DW-1:0]     tx_data;
  logic [IW-1:0]     tx_src_id;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pcie_tx_tlp_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .SRC_ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .src_sop(src_sop), .src_eop(src_eop), .src_credit_ok(src_credit_ok),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_src_id(tx_src_id),
    .busy(busy), .sop_err(sop_err)
  );

  typedef struct {
    logic [2:0]  v, s, e;
    logic        txr;
    logic [31:0] tag;
    logic [2:0]  er;
    logic        eb, etv, es, ee;
    logic [1:0]  eid;
    logic [31:0] etag;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          s, e;
    logic [IW-1:0] id;
  } beat_t;

  vec_t  tbl[$];
  beat_t sb[$];
  int    sop_order[$];

  // reference model state
  bit m_lock, m_first, m_err, m_txv;
  int m_grant, m_ptr;

  // automatic packet sources
  int            beat[NS], len[NS], pkt[NS];
  bit            auto_rr, auto_stop;
  logic [NS-1:0] acc_s;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] lane(input logic [31:0] t);
    return {8{t}};
  endfunction

  function automatic logic [259:0] tx_pack();
    return {tx_data, tx_sop, tx_eop, tx_src_id};
  endfunction

  function automatic vec_t mk(input logic [2:0] v, s, e, input logic txr,
                              input logic [31:0] tag, input logic [2:0] er,
                              input logic eb, etv, es, ee, input logic [1:0] eid,
                              input logic [31:0] etag);
    vec_t r;
    r.v = v; r.s = s; r.e = e; r.txr = txr; r.tag = tag; r.er = er;
    r.eb = eb; r.etv = etv; r.es = es; r.ee = ee; r.eid = eid; r.etag = etag;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [271:0] act, input logic [271:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic [2:0] v, s, e, cr, input logic txr, input logic [31:0] tag);
    src_valid = v; src_sop = s; src_eop = e; src_credit_ok = cr; tx_ready = txr;
    for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = lane(tag + 32'(i));
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [271:0] exp_tx(input logic [31:0] t, input logic s, e, input logic [1:0] id);
    return 272'({lane(t), s, e, id});
  endfunction

  function automatic logic [271:0] all_outs();
    return 272'({tx_valid, tx_data, tx_sop, tx_eop, tx_src_id, src_ready, busy, sop_err});
  endfunction

  task automatic monitor_step();
    logic [NS-1:0] exp_rdy;
    logic [NS-1:0] elig;
    beat_t         b;
    int            g;
    acc_s   = src_valid & src_ready;
    exp_rdy = '0;
    if (m_lock && src_valid[m_grant] && (!m_txv || tx_ready)) exp_rdy[m_grant] = 1'b1;
    chk("rnd src_ready", 272'(src_ready), 272'(exp_rdy));
    chk("rnd busy", 272'(busy), 272'(m_lock));
    chk("rnd sop_err", 272'(sop_err), 272'(m_err));
    chk("rnd tx_valid", 272'(tx_valid), 272'(m_txv));
    if (m_txv && tx_ready) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rnd scoreboard: output beat with nothing expected");
      end else begin
        b = sb.pop_front();
        chk("rnd tx_beat", 272'(tx_pack()), 272'({b.d, b.s, b.e, b.id}));
      end
    end
    if (tx_valid && tx_ready && tx_sop) sop_order.push_back(int'(tx_src_id));
    if (exp_rdy != '0) begin
      g    = m_grant;
      b.d  = src_data[g*DW +: DW];
      b.s  = src_sop[g];
      b.e  = src_eop[g];
      b.id = IW'(g);
      sb.push_back(b);
      if (src_sop[g] && !m_first) m_err = 1'b1;
      m_first = 1'b0;
      if (src_eop[g]) begin
        m_lock = 1'b0;
        m_ptr  = (g + 1) % NS;
      end
      m_txv = 1'b1;
    end else begin
      if (tx_ready) m_txv = 1'b0;
      if (!m_lock) begin
        elig = src_valid & src_sop & src_credit_ok;
        for (int k = 0; k < NS; k++) begin
          if (!m_lock && elig[(m_ptr + k) % NS]) begin
            m_lock  = 1'b1;
            m_grant = (m_ptr + k) % NS;
            m_first = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic auto_step();
    for (int i = 0; i < NS; i++) begin
      if (acc_s[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          pkt[i]++;
          len[i] = auto_rr ? 2 : int'($urandom_range(1, 5));
        end else begin
          beat[i]++;
        end
      end
      if (beat[i] == 0 && auto_stop && !(m_lock && m_grant == i)) src_valid[i] = 1'b0;
      else src_valid[i] = auto_rr ? 1'b1 : ($urandom_range(0, 3) != 0);
      src_sop[i]       = (beat[i] == 0);
      src_eop[i]       = (beat[i] == len[i] - 1);
      src_credit_ok[i] = auto_rr ? 1'b1 : ($urandom_range(0, 3) != 0);
      src_data[i*DW +: DW] = lane({8'(i), 16'(pkt[i]), 8'(beat[i])});
    end
    tx_ready = (auto_rr || auto_stop) ? 1'b1 : ($urandom_range(0, 3) != 0);
  endtask

  task automatic run_cycle();
    smp();
    monitor_step();
    nxt();
    auto_step();
  endtask

  task automatic model_reset();
    m_lock = 0; m_first = 0; m_err = 0; m_txv = 0; m_grant = 0; m_ptr = 0;
    sb.delete();
    sop_order.delete();
    acc_s = '0;
    for (int i = 0; i < NS; i++) begin
      beat[i] = 0;
      len[i]  = 2;
    end
  endtask

  function automatic bit sources_idle();
    for (int i = 0; i < NS; i++) if (beat[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    drv(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset state", all_outs(), 272'(0));
    rst_n = 1'b1;

    // ---------------- directed per-cycle vectors ----------------
    // single 4-beat TLP from src 1
    tbl.push_back(mk(3'b010, 3'b010, 3'b000, 1, 32'h10, 3'b000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b010, 3'b000, 1, 32'h10, 3'b010, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b000, 3'b000, 1, 32'h11, 3'b010, 1, 1, 1, 0, 1, 32'h10));
    tbl.push_back(mk(3'b010, 3'b000, 3'b000, 1, 32'h12, 3'b010, 1, 1, 0, 0, 1, 32'h11));
    tbl.push_back(mk(3'b010, 3'b000, 3'b010, 1, 32'h13, 3'b010, 1, 1, 0, 0, 1, 32'h12));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 1, 32'h00, 3'b000, 0, 1, 0, 1, 1, 32'h13));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 1, 32'h00, 3'b000, 0, 0, 0, 0, 0, 0));
    // one-beat TLP from src 0 (rr_ptr is 2, wraps to 0)
    tbl.push_back(mk(3'b001, 3'b001, 3'b001, 1, 32'h20, 3'b000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3'b001, 3'b001, 3'b001, 1, 32'h20, 3'b001, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 1, 32'h00, 3'b000, 0, 1, 1, 1, 0, 32'h20));
    // 3-beat TLP from src 2 with 5 cycles of backpressure on its last beat
    tbl.push_back(mk(3'b100, 3'b100, 3'b000, 1, 32'h30, 3'b000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3'b100, 3'b100, 3'b000, 1, 32'h30, 3'b100, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3'b100, 3'b000, 3'b000, 1, 32'h31, 3'b100, 1, 1, 1, 0, 2, 32'h30));
    repeat (5) tbl.push_back(mk(3'b100, 3'b000, 3'b100, 0, 32'h32, 3'b000, 1, 1, 0, 0, 2, 32'h31));
    tbl.push_back(mk(3'b100, 3'b000, 3'b100, 1, 32'h32, 3'b100, 1, 1, 0, 0, 2, 32'h31));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 1, 32'h00, 3'b000, 0, 1, 0, 1, 2, 32'h32));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 1, 32'h00, 3'b000, 0, 0, 0, 0, 0, 0));

    foreach (tbl[r]) begin
      drv(tbl[r].v, tbl[r].s, tbl[r].e, 3'b111, tbl[r].txr, tbl[r].tag);
      smp();
      chk($sformatf("vec%0d src_ready", r), 272'(src_ready), 272'(tbl[r].er));
      chk($sformatf("vec%0d busy", r), 272'(busy), 272'(tbl[r].eb));
      chk($sformatf("vec%0d tx_valid", r), 272'(tx_valid), 272'(tbl[r].etv));
      if (tbl[r].etv)
        chk($sformatf("vec%0d tx_beat", r), 272'(tx_pack()),
            exp_tx(tbl[r].etag + 32'(tbl[r].eid), tbl[r].es, tbl[r].ee, tbl[r].eid));
      nxt();
    end

    // ---------------- credit gating (rr_ptr = 0) ----------------
    drv(3'b101, 3'b101, 3'b000, 3'b100, 1, 32'h50);
    smp(); chk("cg idle src_ready", 272'(src_ready), 272'(0));
    nxt();
    smp(); chk("cg grant src2", 272'(src_ready), 272'(3'b100));
    nxt();
    drv(3'b101, 3'b001, 3'b100, 3'b101, 1, 32'h60);
    smp(); chk("cg mid src_ready", 272'(src_ready), 272'(3'b100));
    chk("cg beat0", 272'(tx_pack()), exp_tx(32'h52, 1, 0, 2));
    nxt();
    drv(3'b001, 3'b001, 3'b001, 3'b101, 1, 32'h70);
    smp(); chk("cg idle busy", 272'(busy), 272'(0));
    chk("cg beat1", 272'(tx_pack()), exp_tx(32'h62, 0, 1, 2));
    nxt();
    smp(); chk("cg grant src0", 272'(src_ready), 272'(3'b001));
    nxt();
    drv(3'b000, 3'b000, 3'b000, 3'b111, 1, 32'h0);
    smp(); chk("cg src0 beat", 272'(tx_pack()), exp_tx(32'h70, 1, 1, 0));
    nxt();

    // ---------------- sop repeated mid-packet (rr_ptr = 1) ----------------
    drv(3'b010, 3'b010, 3'b000, 3'b111, 1, 32'h80);
    smp(); chk("se before", 272'(sop_err), 272'(0));
    nxt();
    smp(); chk("se grant src1", 272'(src_ready), 272'(3'b010));
    nxt();
    drv(3'b010, 3'b010, 3'b000, 3'b111, 1, 32'h90);
    smp(); chk("se not yet", 272'(sop_err), 272'(0));
    nxt();
    drv(3'b010, 3'b000, 3'b010, 3'b111, 1, 32'hA0);
    smp(); chk("se set", 272'(sop_err), 272'(1));
    chk("se beat forwarded", 272'(tx_pack()), exp_tx(32'h91, 1, 0, 1));
    nxt();
    drv(3'b000, 3'b000, 3'b000, 3'b111, 1, 32'h0);
    smp(); chk("se last beat", 272'(tx_pack()), exp_tx(32'hA1, 0, 1, 1));
    repeat (4) nxt();
    smp(); chk("se sticky", 272'(sop_err), 272'(1));
    nxt();

    // ---------------- reset, then round-robin with 2-beat TLPs ----------------
    rst_n = 1'b0;
    #1;
    chk("reset clears sop_err", all_outs(), 272'(0));
    model_reset();
    auto_rr = 1; auto_stop = 0;
    for (int i = 0; i < NS; i++) pkt[i] = 0;
    auto_step();
    nxt();
    rst_n = 1'b1;
    for (int c = 0; c < 300 && sop_order.size() < 8; c++) run_cycle();
    if (sop_order.size() < 8) begin
      n_tests++; n_fail++;
      $display("FAIL rr timeout: %0d packets seen, 8 required", sop_order.size());
    end else begin
      for (int k = 0; k < 6; k++)
        chk($sformatf("rr order %0d", k), 272'(sop_order[k]), 272'(k % 3));
    end

    // asynchronous reset while traffic is active
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", all_outs(), 272'(0));
    model_reset();
    auto_step();
    nxt();
    rst_n = 1'b1;
    for (int c = 0; c < 50 && sop_order.size() < 1; c++) run_cycle();
    if (sop_order.size() < 1) begin
      n_tests++; n_fail++;
      $display("FAIL post-reset timeout: 0 packets seen, 1 required");
    end else begin
      chk("post-reset first grant", 272'(sop_order[0]), 272'(0));
    end

    // ---------------- random traffic against the reference model ----------------
    auto_rr = 0;
    for (int c = 0; c < 3000; c++) run_cycle();
    auto_stop = 1;
    for (int c = 0; c < 500 && !(!m_lock && !m_txv && sb.size() == 0 && sources_idle()); c++)
      run_cycle();
    if (m_lock || m_txv || sb.size() != 0 || !sources_idle()) begin
      n_tests++; n_fail++;
      $display("FAIL drain timeout: %0d beats still expected", sb.size());
    end
    smp();
    chk("drain tx_valid", 272'(tx_valid), 272'(0));
    chk("drain busy", 272'(busy), 272'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
